// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

    localparam int DIV_WIDTH = 4;
    localparam int CNT_W     = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/cla_sub_stage.sv
// Combinational A - B as A + ~B + 1 with full carry lookahead.
module cla_sub_stage #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         cout
);

    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;

    assign g = a & ~b;
    assign p = a ^ ~b;

    // Each carry is a flat sum of products of g/p terms, no ripple chain.
    always_comb begin
        logic pp;
        c    = '0;
        c[0] = 1'b1;
        for (int i = 0; i < N; i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | pp;
        end
    end

    assign diff = p ^ c[N-1:0];
    assign cout = c[N];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   r_reg;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   trial;
    logic             no_borrow;
    logic [WIDTH:0]   nxt_r;
    logic [WIDTH-1:0] nxt_q;
    logic             unused_r_msb;

    assign partial = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};

    cla_sub_stage #(
        .N (WIDTH + 1)
    ) u_sub (
        .a    (partial),
        .b    ({1'b0, d_reg}),
        .diff (trial),
        .cout (no_borrow)
    );

    assign nxt_r = no_borrow ? trial : partial;
    assign nxt_q = {q_reg[WIDTH-2:0], no_borrow};
    assign busy  = (state == RUN);

    // Remainder never exceeds WIDTH bits after a step; the top bit is scratch.
    assign unused_r_msb = r_reg[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE, FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        if (divisor != '0) begin
                            d_reg <= divisor;
                            q_reg <= dividend;
                            r_reg <= '0;
                            cnt   <= CW'(WIDTH - 1);
                            state <= RUN;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= FIN;
                        end
                    end
                end
                RUN: begin
                    r_reg <= nxt_r;
                    q_reg <= nxt_q;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        quotient    <= nxt_q;
                        remainder   <= nxt_r[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        state       <= FIN;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
